seg_display_scanner: RTL and testbench
======================================

Name: seg_display_scanner

Overview:
Time-multiplexed scan controller for the 4-digit 7-segment display. It holds a double-buffered 4-digit BCD value and dot mask, and steps through the digits at a fixed refresh rate. For each digit it presents the digit code, digit index and dot control to the downstream BCD-to-segment decoder, and drives the active-low anode lines with a ghost-suppression blanking interval. New values from the game logic are committed only at frame boundaries, so a value never tears mid-frame.

Parameters:
REFRESH_DIV, 100000, CLK cycles per digit slot (100 MHz gives 1 kHz per digit, 250 Hz per frame); must be >= 2
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV

Ports:
CLK  input  1  system clock; every register updates on the rising edge
RESET  input  1  synchronous, active-high reset
ENABLE  input  1  1 = scanning; 0 = display dark
LOAD  input  1  one-cycle strobe; captures DIGITS_IN/DOTS_IN into the pending buffer
DIGITS_IN  input  16  four BCD nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3
DOTS_IN  input  4  dot enable per digit, 1 = lit; bit n is digit n
LZB_IN  input  1  1 = leading-zero blanking on
BIN_OUT  output  4  digit code to decoder; 4'hF = blank
SEG_SELECT_OUT  output  2  current digit index to decoder
DOT_OUT  output  1  decoder dot input; 0 = dot lit (active-low segment), 1 = off
ANODE_OUT  output  4  active-low one-hot anode drive
UPDATED  output  1  one-cycle pulse in the cycle a pending value is committed

Behaviour:
- Reset state (RESET=1 at an edge): tick counter 0, digit index 0, active digits 16'h0000, active dots 0, pending flag 0, BIN_OUT 4'h0, SEG_SELECT_OUT 0, DOT_OUT 1, ANODE_OUT 4'b1111, UPDATED 0. RESET overrides every other input, including mid-frame and during LOAD.
- Tick counter runs 0..REFRESH_DIV-1 and wraps. At terminal count the digit index advances 0→1→2→3→0.
- Outputs are registered. BIN_OUT, SEG_SELECT_OUT and DOT_OUT update in the same edge as the index advance, so they always match the new index.
- Slot phases:
  - BLANK while counter < BLANK_CYCLES: ANODE_OUT=4'b1111.
  - ON for the rest of the slot: ANODE_OUT has a 0 only at bit [index].
  - The phase is derived from the registered counter, so ANODE_OUT changes one cycle after the counter crosses the boundary.
- LOAD: DIGITS_IN/DOTS_IN are written to the pending buffer and the pending flag is set. A later LOAD before commit overwrites the pending buffer (last write wins).
- Commit: occurs on the edge where the index wraps 3→0 with the pending flag set. Active buffer ← pending buffer, flag cleared, UPDATED=1 for that cycle. Digit 0 of the new frame already uses the new data.
- LOAD in the same cycle as a commit: the commit uses the previously pending data, and the new LOAD data becomes pending for the next frame. If nothing was pending, no commit happens that cycle and the LOAD data is committed at the next wrap.
- ENABLE=0:
  - ANODE_OUT=4'b1111; counter and index are held at 0.
  - Any pending value commits on the next edge, with an UPDATED pulse.
  - On ENABLE 0→1, scanning starts at digit 0 with a BLANK phase.
- Leading-zero blanking (LZB_IN=1): digit n (n=3..1) outputs BIN_OUT=4'hF if it and every higher digit are 0. Digit 0 is never blanked. The dot follows the mask regardless of blanking.
- Non-BCD nibbles (A–F) pass through unchanged; the decoder blanks them.
- DOT_OUT = ~active_dots[index].

Decomposition:
- Shared package display_pkg holds: NUM_DIGITS=4, BLANK_CODE=4'hF, ANODES_OFF=4'b1111, and the phase enum {PH_BLANK, PH_ON}.
- One sub-module, refresh_tick_gen, parameterised by REFRESH_DIV. Outputs: the counter value and a terminal-count pulse. Inputs: CLK, RESET, and a clear (driven by ~ENABLE).
- The scanner itself contains the index register, the double buffer, the LZB logic and the output registers.

Test Plan:
- (All runs use REFRESH_DIV=8, BLANK_CYCLES=2.)
- Reset then LOAD 16'h1234, dots 4'b0000, LZB=0 → UPDATED pulses once. BIN_OUT sequence 4,3,2,1 with SEG_SELECT_OUT 0,1,2,3, each held 8 cycles. ANODE_OUT is 1111 for 2 cycles, then 1110 / 1101 / 1011 / 0111.
- LOAD 16'h0007 with LZB=1 → digits 3..1 output 4'hF and digit 0 outputs 7. Same value with LZB=0 → 0,0,0 shown.
- LOAD 16'h5555 mid-frame at digit 1, then 16'h6666 at digit 2 → the current frame completes with the old value, the next frame shows 6666, and UPDATED pulses exactly once.
- LOAD asserted on the 3→0 wrap edge while 16'hAAAA is pending → the new frame shows AAAA and the LOAD data appears one frame later; two UPDATED pulses, 32 cycles apart.
- DOTS_IN 4'b0101 → DOT_OUT=0 on digits 0 and 2, 1 on digits 1 and 3.
- ENABLE low mid-slot → ANODE_OUT=1111 next cycle and a pending LOAD commits. RESET asserted mid-slot → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment scan path.
// Used by the scanner and its testbench.
package display_pkg;
  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  typedef enum logic {
    PH_BLANK,
    PH_ON
  } phase_t;
endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running slot counter, 0..REFRESH_DIV-1, with terminal-count pulse.
// CLEAR holds the count at zero and suppresses the pulse.
module refresh_tick_gen #(
  parameter  int REFRESH_DIV = 100000,
  localparam int CW          = $clog2(REFRESH_DIV)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CLEAR,
  output logic [CW-1:0] COUNT,
  output logic          TC
);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  always_ff @(posedge CLK) begin
    if (RESET | CLEAR) begin
      COUNT <= '0;
    end else if (COUNT == LAST) begin
      COUNT <= '0;
    end else begin
      COUNT <= COUNT + CW'(1);
    end
  end

  assign TC = ~CLEAR & (COUNT == LAST);
endmodule

// File: rtl/seg_display_scanner.sv
// 4-digit 7-segment scan controller with frame-aligned double buffer,
// leading-zero blanking and anode blanking at the start of each slot.
module seg_display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        LOAD,
  input  logic [15:0] DIGITS_IN,
  input  logic [3:0]  DOTS_IN,
  input  logic        LZB_IN,
  output logic [3:0]  BIN_OUT,
  output logic [1:0]  SEG_SELECT_OUT,
  output logic        DOT_OUT,
  output logic [3:0]  ANODE_OUT,
  output logic        UPDATED
);
  localparam int            CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic          tc;
  logic          clear;

  assign clear = ~ENABLE;

  refresh_tick_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .CLK  (CLK),
    .RESET(RESET),
    .CLEAR(clear),
    .COUNT(cnt),
    .TC   (tc)
  );

  logic [1:0]  idx;
  logic [1:0]  idx_nxt;
  logic [15:0] act_digits;
  logic [15:0] act_nxt;
  logic [15:0] pend_digits;
  logic [3:0]  act_dots;
  logic [3:0]  dots_nxt;
  logic [3:0]  pend_dots;
  logic        pend;
  logic        commit;
  logic [3:0]  lz;
  logic        above;
  logic [3:0]  nib;
  phase_t      phase;

  always_comb begin
    commit   = pend & (clear | (tc & (idx == 2'd3)));
    idx_nxt  = clear ? 2'd0 : idx + {1'b0, tc};
    act_nxt  = commit ? pend_digits : act_digits;
    dots_nxt = commit ? pend_dots : act_dots;
    phase    = (cnt < BLANK_CNT) ? PH_BLANK : PH_ON;
  end

  // lz[n] is set when digit n and every digit above it are zero
  always_comb begin
    lz    = '0;
    above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      above = above & (act_nxt[4*i +: 4] == 4'h0);
      lz[i] = above;
    end
    nib = act_nxt[{idx_nxt, 2'b00} +: 4];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx            <= 2'd0;
      act_digits     <= '0;
      act_dots       <= '0;
      pend_digits    <= '0;
      pend_dots      <= '0;
      pend           <= 1'b0;
      BIN_OUT        <= 4'h0;
      SEG_SELECT_OUT <= 2'd0;
      DOT_OUT        <= 1'b1;
      ANODE_OUT      <= ANODES_OFF;
      UPDATED        <= 1'b0;
    end else begin
      idx        <= idx_nxt;
      act_digits <= act_nxt;
      act_dots   <= dots_nxt;
      if (commit) begin
        pend <= 1'b0;
      end
      // a LOAD on the commit edge becomes pending for the next frame
      if (LOAD) begin
        pend_digits <= DIGITS_IN;
        pend_dots   <= DOTS_IN;
        pend        <= 1'b1;
      end
      BIN_OUT        <= (LZB_IN & lz[idx_nxt]) ? BLANK_CODE : nib;
      SEG_SELECT_OUT <= idx_nxt;
      DOT_OUT        <= ~dots_nxt[idx_nxt];
      if (clear | (phase == PH_BLANK)) begin
        ANODE_OUT <= ANODES_OFF;
      end else begin
        ANODE_OUT <= ~(4'b0001 << idx);
      end
      UPDATED <= commit;
    end
  end
endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner: a time-based reference
// model predicts every registered output cycle; a monitor compares.
module tb_seg_display_scanner;
  localparam int DIV = 8;
  localparam int BLK = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] DIGITS_IN = '0;
  logic [3:0]  DOTS_IN = '0;
  logic        LZB_IN = 1'b0;
  logic [3:0]  BIN_OUT;
  logic [1:0]  SEG_SELECT_OUT;
  logic        DOT_OUT;
  logic [3:0]  ANODE_OUT;
  logic        UPDATED;

  seg_display_scanner #(
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ENABLE        (ENABLE),
    .LOAD          (LOAD),
    .DIGITS_IN     (DIGITS_IN),
    .DOTS_IN       (DOTS_IN),
    .LZB_IN        (LZB_IN),
    .BIN_OUT       (BIN_OUT),
    .SEG_SELECT_OUT(SEG_SELECT_OUT),
    .DOT_OUT       (DOT_OUT),
    .ANODE_OUT     (ANODE_OUT),
    .UPDATED       (UPDATED)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] bin;
    logic [1:0] sel;
    logic       dot;
    logic [3:0] an;
    logic       upd;
  } obs_t;

  obs_t exp_q[$];
  int   upd_t[$];
  int   checks = 0;
  int   errors = 0;
  int   sb_n = 0;
  int   cyc = 0;

  // reference model: t counts scanning cycles since scan start
  int          t = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_pend = '0;
  logic [3:0]  m_actd = '0;
  logic [3:0]  m_pendd = '0;
  bit          m_pv = 0;

  function automatic int m_idx();
    return (t / DIV) % 4;
  endfunction

  function automatic logic [3:0] shown(logic [15:0] v, int n, logic lzb);
    if (lzb && n > 0 && (v >> (4 * n)) == 16'h0) return 4'hF;
    return v[4*n +: 4];
  endfunction

  task automatic model_step();
    obs_t       e;
    int         cnt;
    int         idx;
    int         ni;
    bit         commit;
    logic [3:0] oh;
    if (RESET) begin
      t = 0;
      m_act = '0;
      m_actd = '0;
      m_pv = 0;
      e.bin = 4'h0;
      e.sel = 2'd0;
      e.dot = 1'b1;
      e.an = 4'hF;
      e.upd = 1'b0;
    end else begin
      cnt = t % DIV;
      idx = (t / DIV) % 4;
      commit = m_pv && (!ENABLE || (cnt == DIV - 1 && idx == 3));
      oh = 4'b0001 << idx;
      e.an = (!ENABLE || cnt < BLK) ? 4'hF : ~oh;
      if (commit) begin
        m_act = m_pend;
        m_actd = m_pendd;
        m_pv = 0;
      end
      if (LOAD) begin
        m_pend = DIGITS_IN;
        m_pendd = DOTS_IN;
        m_pv = 1;
      end
      t = ENABLE ? t + 1 : 0;
      ni = (t / DIV) % 4;
      e.bin = shown(m_act, ni, LZB_IN);
      e.sel = 2'(ni);
      e.dot = ~m_actd[ni];
      e.upd = commit;
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    obs_t e;
    obs_t g;
    @(negedge CLK);
    cyc++;
    if (UPDATED === 1'b1) upd_t.push_back(cyc);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g.bin = BIN_OUT;
      g.sel = SEG_SELECT_OUT;
      g.dot = DOT_OUT;
      g.an = ANODE_OUT;
      g.upd = UPDATED;
      checks++;
      sb_n++;
      if (g !== e) begin
        errors++;
        if (errors <= 30)
          $display("FAIL scan cyc=%0d got bin=%h sel=%0d dot=%b an=%b upd=%b exp bin=%h sel=%0d dot=%b an=%b upd=%b",
                   cyc, g.bin, g.sel, g.dot, g.an, g.upd,
                   e.bin, e.sel, e.dot, e.an, e.upd);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic load(logic [15:0] d, logic [3:0] m);
    LOAD = 1'b1;
    DIGITS_IN = d;
    DOTS_IN = m;
    step();
    LOAD = 1'b0;
  endtask

  task automatic check_eq(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic wait_idx(int k);
    for (int i = 0; i < 40 && m_idx() != k; i++) step();
    check_eq("wait_idx", m_idx(), k);
  endtask

  task automatic wait_wrap();
    for (int i = 0; i < 40; i++) begin
      if (t % DIV == DIV - 1 && m_idx() == 3) break;
      step();
    end
    check_eq("wait_wrap", t % DIV + 8 * m_idx(), (DIV - 1) + 24);
  endtask

  initial begin
    int gap;
    logic [15:0] d;
    step(2);
    RESET = 1'b0;
    ENABLE = 1'b1;
    step(3);

    upd_t.delete();
    load(16'h1234, 4'b0000);
    step(40);
    check_eq("upd_1234", upd_t.size(), 1);

    LZB_IN = 1'b1;
    load(16'h0007, 4'b0000);
    step(40);
    LZB_IN = 1'b0;
    step(32);

    wait_idx(1);
    upd_t.delete();
    load(16'h5555, 4'b0000);
    wait_idx(2);
    load(16'h6666, 4'b0000);
    step(64);
    check_eq("upd_last_wins", upd_t.size(), 1);

    wait_idx(1);
    upd_t.delete();
    load(16'hAAAA, 4'b1111);
    wait_wrap();
    load(16'hBBBB, 4'b0000);
    step(40);
    check_eq("upd_collide_n", upd_t.size(), 2);
    gap = (upd_t.size() == 2) ? upd_t[1] - upd_t[0] : -1;
    check_eq("upd_collide_gap", gap, 32);

    load(16'h8421, 4'b0101);
    step(40);

    wait_idx(1);
    step(3);
    upd_t.delete();
    load(16'h4321, 4'b1010);
    ENABLE = 1'b0;
    step(4);
    check_eq("upd_disable", upd_t.size(), 1);
    ENABLE = 1'b1;
    step(40);

    wait_idx(2);
    step(3);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    step(20);

    repeat (2500) begin
      for (int i = 0; i < 4; i++)
        d[4*i +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
      DIGITS_IN = d;
      DOTS_IN = 4'($urandom);
      LOAD = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) LZB_IN = ~LZB_IN;
      if (ENABLE) ENABLE = ($urandom_range(0, 49) != 0);
      else ENABLE = ($urandom_range(0, 2) == 0);
      RESET = ($urandom_range(0, 299) == 0);
      step();
    end

    RESET = 1'b0;
    ENABLE = 1'b1;
    LOAD = 1'b0;
    step(2);
    @(negedge CLK);
    #1;
    check_eq("sb_drain", exp_q.size(), 0);
    check_eq("sb_alive", int'(sb_n > 2500), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
